// File: rtl/pipe_flow_ctrl.sv
// Front-end IF/ID/DP flow controller: decode-valid tracking, stall/kill generation, flush and trap sequencing.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_flow_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_CNT_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  if_valid_i,
  input  logic                  illegal_inst_i,
  input  logic                  rob_full_i,
  input  logic                  rs_full_i,
  input  logic                  freelist_empty_i,
  input  logic                  mispredict_i,
  input  logic                  redirect_ack_i,
  output logic                  stall_IF_o,
  output logic                  kill_IF_o,
  output logic                  stall_ID_o,
  output logic                  kill_ID_o,
  output logic                  stall_DP_o,
  output logic                  kill_DP_o,
  output logic                  id_valid_o,
  output logic                  trap_o,
  output logic [PERF_CNT_W-1:0] stall_cycles_o,
  output logic [PERF_CNT_W-1:0] flush_cycles_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    TRAP  = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             id_valid_reg, id_valid_next;
  logic             dp_block;
  logic             stall_if, kill_if, stall_id, kill_id, stall_dp, kill_dp, trap;

  assign dp_block = id_valid_reg & (rob_full_i | rs_full_i | freelist_empty_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg    <= RUN;
      cnt_reg      <= '0;
      id_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      id_valid_reg <= id_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    id_valid_next = id_valid_reg;
    stall_if      = 1'b0;
    kill_if       = 1'b0;
    stall_id      = 1'b0;
    kill_id       = 1'b0;
    stall_dp      = 1'b0;
    kill_dp       = 1'b0;
    trap          = 1'b0;
    // A redirect from commit overrides whatever the current state is doing.
    if (mispredict_i) begin
      kill_if       = 1'b1;
      kill_id       = 1'b1;
      kill_dp       = 1'b1;
      state_next    = FLUSH;
      cnt_next      = CNT_LOAD;
      id_valid_next = 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          stall_if = dp_block;
          stall_id = dp_block;
          stall_dp = dp_block;
          id_valid_next = dp_block ? id_valid_reg : if_valid_i;
          if (illegal_inst_i && id_valid_reg && !dp_block) begin
            state_next    = TRAP;
            id_valid_next = 1'b0;
          end
        end
        TRAP: begin
          trap          = 1'b1;
          stall_if      = 1'b1;
          kill_id       = 1'b1;
          id_valid_next = 1'b0;
          if (redirect_ack_i) begin
            state_next = FLUSH;
            cnt_next   = CNT_LOAD;
          end
        end
        FLUSH: begin
          kill_if       = 1'b1;
          kill_id       = 1'b1;
          kill_dp       = 1'b1;
          id_valid_next = 1'b0;
          if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
          else               state_next = RUN;
        end
        default: begin
          state_next    = RUN;
          id_valid_next = 1'b0;
        end
      endcase
    end
  end

  // Gating with reset keeps every output low while reset is held, even with mispredict_i active.
  assign stall_IF_o = stall_if & reset_n_i;
  assign kill_IF_o  = kill_if & reset_n_i;
  assign stall_ID_o = stall_id & reset_n_i;
  assign kill_ID_o  = kill_id & reset_n_i;
  assign stall_DP_o = stall_dp & reset_n_i;
  assign kill_DP_o  = kill_dp & reset_n_i;
  assign id_valid_o = id_valid_reg & reset_n_i;
  assign trap_o     = trap & reset_n_i;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_dp && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if ((state_reg == FLUSH) && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt_reg;
  assign flush_cycles_o = flush_cnt_reg;
`else
  assign stall_cycles_o = '0;
  assign flush_cycles_o = '0;
`endif

endmodule
